mem_arbiter: RTL

Single-port memory arbiter for the processor. It lets one unified RAM be shared between instruction fetch and the load/store data path, replacing the separate instruction ROM. It sits between the `pc`/fetch logic and `control` on one side and the `ram` block on the other. It grants at most one RAM access per cycle and tracks which requester owns each read response.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Processor-wide RAM command codes, shared by ram, control and the memory arbiter.
package cpu_pkg;

    localparam logic [1:0] RAM_NOP = 2'd0;
    localparam logic [1:0] RAM_RD  = 2'd1;
    localparam logic [1:0] RAM_WR  = 2'd2;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types local to the memory arbiter: response owner, round-robin pointer, helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } own_t;

    typedef enum logic {
        LAST_FETCH = 1'b0,
        LAST_DATA  = 1'b1
    } last_t;

    localparam int unsigned STARVE_W = 4;

    // A data request only competes when it carries a real RAM command.
    function automatic logic is_access(input logic [1:0] action);
        return (action == cpu_pkg::RAM_RD) || (action == cpu_pkg::RAM_WR);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests.
// MEMARB_RR_EN selects round-robin on a last-winner pointer instead of fixed priority.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_f_act,
    input  logic                i_d_act,
`ifdef MEMARB_RR_EN
    input  last_t               i_last,
`else
    input  logic [STARVE_W-1:0] i_starve_cnt,
`endif
    output logic                o_f_win,
    output logic                o_d_win
);

    logic w_f_first;

`ifdef MEMARB_RR_EN
    assign w_f_first = (i_last == LAST_DATA);
`else
    assign w_f_first = (i_starve_cnt == STARVE_W'(STARVE_MAX));
`endif

    always_comb begin
        o_f_win = i_f_act & (~i_d_act | w_f_first);
        o_d_win = i_d_act & ~o_f_win;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the load/store path.
// Optional build macro MEMARB_RR_EN: round-robin arbitration instead of data priority.
module mem_arbiter
    import cpu_pkg::*;
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_f_req,
    input  logic [AW-1:0] i_f_addr,
    output logic          o_f_gnt,
    output logic          o_f_valid,
    output logic [DW-1:0] o_f_data,
    input  logic          i_d_req,
    input  logic [1:0]    i_d_action,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_valid,
    output logic [DW-1:0] o_d_rdata,
    output logic [1:0]    o_ram_action,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_in,
    input  logic [DW-1:0] i_ram_out,
    output logic          o_busy
);

    logic w_f_act;
    logic w_d_act;
    logic w_f_win;
    logic w_d_win;
    own_t r_own;
    own_t w_own_nxt;

    assign w_f_act = i_f_req;
    assign w_d_act = i_d_req & is_access(i_d_action);

`ifdef MEMARB_RR_EN
    last_t r_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= LAST_DATA;
        end else if (o_f_gnt) begin
            r_last <= LAST_FETCH;
        end else if (o_d_gnt) begin
            r_last <= LAST_DATA;
        end
    end

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_f_act (w_f_act),
        .i_d_act (w_d_act),
        .i_last  (r_last),
        .o_f_win (w_f_win),
        .o_d_win (w_d_win)
    );
`else
    logic [STARVE_W-1:0] r_starve_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (i_f_req && !o_f_gnt) begin
            if (r_starve_cnt != STARVE_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_f_act      (w_f_act),
        .i_d_act      (w_d_act),
        .i_starve_cnt (r_starve_cnt),
        .o_f_win      (w_f_win),
        .o_d_win      (w_d_win)
    );
`endif

    // Grants are suppressed combinationally while reset is held.
    assign o_f_gnt = w_f_win & ~i_rst;
    assign o_d_gnt = w_d_win & ~i_rst;

    always_comb begin
        o_ram_action = RAM_NOP;
        o_ram_addr   = '0;
        o_ram_in     = '0;
        if (o_f_gnt) begin
            o_ram_action = RAM_RD;
            o_ram_addr   = i_f_addr;
        end else if (o_d_gnt) begin
            o_ram_action = i_d_action;
            o_ram_addr   = i_d_addr;
            o_ram_in     = i_d_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_own <= OWN_NONE;
        end else begin
            r_own <= w_own_nxt;
        end
    end

    always_comb begin
        w_own_nxt = OWN_NONE;
        if (o_f_gnt) begin
            w_own_nxt = OWN_FETCH;
        end else if (o_d_gnt) begin
            w_own_nxt = OWN_DATA;
        end
    end

    always_comb begin
        o_f_valid = (r_own == OWN_FETCH);
        o_d_valid = (r_own == OWN_DATA);
        o_busy    = (r_own != OWN_NONE);
        o_f_data  = i_ram_out;
        o_d_rdata = i_ram_out;
    end

endmodule
